// File: rtl/wide_mult_pkg.sv
// Shared widths and latency for the wide multiplier and its result serializer.
package wide_mult_pkg;
   localparam int WM_RES_W   = 256;
   localparam int WM_BEAT_W  = 64;
   localparam int WM_BEATS   = WM_RES_W / WM_BEAT_W;
   localparam int WM_LATENCY = 43;

   typedef logic [WM_RES_W-1:0]  wm_result_t;
   typedef logic [WM_BEAT_W-1:0] wm_beat_t;
endpackage

// File: rtl/wide_mult_res_fifo.sv
// Single-clock result FIFO; exposes the head and the entry behind it so the
// serializer can start the next result without a bubble.
module wide_mult_res_fifo #(
   parameter int WIDTH = 256,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic [WIDTH-1:0]           rd_data_next,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;

   assign rd_ptr_nxt   = rd_ptr + 1'b1;
   assign rd_data      = mem[rd_ptr];
   assign rd_data_next = mem[rd_ptr_nxt];
   assign full         = (count == (AW+1)'(DEPTH));
   assign empty        = (count == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr_nxt;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/wide_mult_result_serializer.sv
// Recovers the result strobe of wide_mult_top from start, buffers results and
// streams each one out as BEAT_W-wide beats, least significant first.
module wide_mult_result_serializer
   import wide_mult_pkg::*;
#(
   parameter int LATENCY = WM_LATENCY,
   parameter int DEPTH   = 8,
   parameter int RES_W   = WM_RES_W,
   parameter int BEAT_W  = WM_BEAT_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [RES_W-1:0]        return_val,
   output logic [BEAT_W-1:0]       m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    overflow
);
   localparam int BEATS = RES_W / BEAT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OCC_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   logic [LATENCY-1:0]           tap;
   logic                         res_vld;
   logic                         push;
   logic                         pop;
   logic                         full;
   logic                         empty;
   logic [OCC_W-1:0]             count;
   logic [RES_W-1:0]             head;
   logic [RES_W-1:0]             head_next;
   logic [BEATS-1:0][BEAT_W-1:0] head_beats;
   logic [BEATS-1:0][BEAT_W-1:0] next_beats;
   logic [CNT_W-1:0]             cnt;
   logic [CNT_W-1:0]             cnt_inc;
   logic                         accept;
   logic                         last_acc;
   logic                         load_en;
   logic                         load_valid;
   logic [CNT_W-1:0]             load_cnt;
   logic [BEAT_W-1:0]            load_data;

   always_ff @(posedge clk) begin
      if (reset) tap <= '0;
      else       tap <= {tap[LATENCY-2:0], start};
   end
   assign res_vld = tap[LATENCY-1];

   // A full FIFO still takes a result when its head leaves in the same cycle.
   assign accept   = m_valid && m_ready;
   assign last_acc = accept && (cnt == LAST_CNT);
   assign pop      = last_acc;
   assign push     = res_vld && (!full || last_acc);

   wide_mult_res_fifo #(
      .WIDTH (RES_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .pop          (pop),
      .wr_data      (return_val),
      .rd_data      (head),
      .rd_data_next (head_next),
      .full         (full),
      .empty        (empty),
      .count        (count)
   );

   assign head_beats = head;
   assign next_beats = head_next;
   assign cnt_inc    = cnt + 1'b1;
   assign occupancy  = count;

   // Output register reloads only when empty or when its beat is taken.
   always_comb begin
      load_en    = 1'b0;
      load_valid = 1'b0;
      load_cnt   = '0;
      load_data  = '0;
      if (!m_valid) begin
         if (!empty) begin
            load_en    = 1'b1;
            load_valid = 1'b1;
            load_data  = head_beats[0];
         end
      end else if (accept) begin
         load_en = 1'b1;
         if (!last_acc) begin
            load_valid = 1'b1;
            load_cnt   = cnt_inc;
            load_data  = head_beats[cnt_inc];
         end else if (count > OCC_W'(1)) begin
            load_valid = 1'b1;
            load_data  = next_beats[0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_last   <= 1'b0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (load_en) begin
            m_valid <= load_valid;
            m_data  <= load_data;
            m_last  <= load_valid && (load_cnt == LAST_CNT);
            cnt     <= load_cnt;
         end
         if (res_vld && full && !last_acc) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_wide_mult_result_serializer.sv
// Directed bench: a pure-delay stand-in for wide_mult_top feeds the serializer,
// and a beat scoreboard plus hold monitor checks the output stream.
module tb_wide_mult_result_serializer;
   localparam int LAT = 43;
   localparam logic [255:0] T1_EXP = 256'h2_000000000000000A;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [255:0] in_val;
   logic [255:0] return_val;
   logic [63:0]  m_data;
   logic         m_valid;
   logic         m_ready;
   logic         m_last;
   logic [3:0]   occupancy;
   logic         overflow;

   logic [255:0] pipe [LAT];
   exp_t         exp_q[$];
   bit           mon_en = 1'b0;
   logic         stall_prev = 1'b0;
   logic [63:0]  hold_data = '0;
   logic         hold_last = 1'b0;
   int           n_checks = 0;
   int           n_pass = 0;

   wide_mult_result_serializer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .return_val (return_val),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .occupancy  (occupancy),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Stand-in multiplier: the operand result appears LAT edges after start.
   always @(posedge clk) begin
      pipe[0] <= in_val;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign return_val = pipe[LAT-1];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Negedge monitor: a beat shown with m_ready high is taken at the next edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (stall_prev) begin
            check("hold_valid", 256'(m_valid), 256'(1));
            check("hold_data", 256'(m_data), 256'(hold_data));
            check("hold_last", 256'(m_last), 256'(hold_last));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 256'(m_data), 256'h0);
               check("extra_beat_present", 256'(1), 256'(0));
            end else begin
               check("beat_data", 256'(m_data), 256'(exp_q[0].data));
               check("beat_last", 256'(m_last), 256'(exp_q[0].last));
               exp_q.delete(0);
            end
         end
         stall_prev <= m_valid && !m_ready;
         hold_data  <= m_data;
         hold_last  <= m_last;
      end else begin
         stall_prev <= 1'b0;
      end
   end

   function automatic logic signed [255:0] sx(input int v);
      return {{224{v[31]}}, v};
   endfunction

   function automatic logic signed [255:0] model(input int a, b, c, d, e);
      logic signed [255:0] ea, eb, ec, ed, ee;
      ea = sx(a); eb = sx(b); ec = sx(c); ed = sx(d); ee = sx(e);
      return ea + (eb <<< 64) + ec * (ed + ((ec * ee) >>> 1));
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [255:0] v);
      for (int k = 0; k < 4; k++) exp_q.push_back('{data: v[k*64 +: 64], last: (k == 3)});
   endtask

   task automatic send_one(input logic [255:0] v, input bit keep);
      start  = 1'b1;
      in_val = v;
      if (keep) push_exp(v);
      cyc();
      start = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < budget) begin
         cyc();
         n++;
      end
      check(tag, 256'(n < budget), 256'(1));
   endtask

   task automatic rst_pulse();
      mon_en = 1'b0;
      reset  = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      exp_q.delete();
      mon_en = 1'b1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 256'(m_valid), 256'(0));
      check({tag, "_data"}, 256'(m_data), 256'(0));
      check({tag, "_last"}, 256'(m_last), 256'(0));
      check({tag, "_occ"}, 256'(occupancy), 256'(0));
      check({tag, "_ovf"}, 256'(overflow), 256'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      m_ready = 1'b0;
      in_val  = '0;
      repeat (3) cyc();
      check_idle("reset");
      reset  = 1'b0;
      mon_en = 1'b1;

      // T1: single result, first beat exactly LAT+1 edges after start.
      m_ready = 1'b1;
      push_exp(T1_EXP);
      send_one(model(2, 2, 2, 2, 2), 1'b0);
      repeat (LAT) cyc();
      check("t1_not_yet_valid", 256'(m_valid), 256'(0));
      cyc();
      check("t1_valid", 256'(m_valid), 256'(1));
      check("t1_beat0", 256'(m_data), 256'hA);
      drain("t1_drain", 20);

      // T2: burst of 9 with no consumer; the 9th is dropped.
      m_ready = 1'b0;
      for (int i = 0; i < 9; i++)
         send_one({64'(i + 400), 64'(i + 300), 64'(i + 200), 64'(i + 100)}, (i < 8));
      repeat (42) cyc();
      check("t2_occ_full", 256'(occupancy), 256'(8));
      check("t2_no_ovf", 256'(overflow), 256'(0));
      cyc();
      check("t2_occ_after_drop", 256'(occupancy), 256'(8));
      check("t2_ovf", 256'(overflow), 256'(1));
      m_ready = 1'b1;
      drain("t2_drain", 60);
      check("t2_ovf_sticky", 256'(overflow), 256'(1));
      rst_pulse();
      check("rst_clears_ovf", 256'(overflow), 256'(0));

      // T3: backpressure pattern 1,0,0 across two back-to-back results.
      m_ready = 1'b0;
      send_one({64'h1111, 64'h2222, 64'h3333, 64'h4444}, 1'b1);
      send_one({64'h5555, 64'h6666, 64'h7777, 64'h8888}, 1'b1);
      for (int n = 0; n < 100 && !m_valid; n++) cyc();
      check("t3_valid", 256'(m_valid), 256'(1));
      for (int k = 0; k < 24; k++) begin
         m_ready = (k % 3 == 0);
         cyc();
      end
      m_ready = 1'b1;
      drain("t3_drain", 40);

      // T4: full FIFO, last beat taken in the same edge as a new result.
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         send_one({64'(i + 40), 64'(i + 30), 64'(i + 20), 64'(i + 10)}, 1'b1);
      repeat (43) cyc();
      check("t4_occ_full", 256'(occupancy), 256'(8));
      send_one({64'hDEAD, 64'hBEEF, 64'hCAFE, 64'hF00D}, 1'b1);
      repeat (39) cyc();
      m_ready = 1'b1;
      repeat (4) cyc();
      check("t4_occ", 256'(occupancy), 256'(8));
      check("t4_no_ovf", 256'(overflow), 256'(0));
      drain("t4_drain", 60);

      // T5: reset during beat 2 with three starts still in the delay line.
      m_ready = 1'b1;
      send_one({64'hD3, 64'hC2, 64'hB1, 64'hA0}, 1'b1);
      repeat (9) cyc();
      for (int i = 0; i < 3; i++) send_one({4{64'(i + 77)}}, 1'b0);
      repeat (34) cyc();
      check("t5_beat2", 256'(m_data), 256'hC2);
      mon_en = 1'b0;
      reset  = 1'b1;
      cyc();
      check_idle("t5_reset");
      reset = 1'b0;
      exp_q.delete();
      mon_en = 1'b1;
      repeat (60) cyc();
      check("t5_quiet_valid", 256'(m_valid), 256'(0));
      check("t5_quiet_occ", 256'(occupancy), 256'(0));

      // T6: 47 model vectors spaced 4 cycles apart.
      m_ready = 1'b1;
      for (int i = 0; i < 47; i++) begin
         send_one(model(i * 7919 - 150000, 3 - i * 5, i - 23, i * i - 400, 1000 - i * 31), 1'b1);
         repeat (3) cyc();
      end
      drain("t6_drain", 300);
      check("t6_no_ovf", 256'(overflow), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
